// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding unit: forwarding select codes and
// the shadow-stage record that follows each instruction down EX, MEM and WB.
package hazard_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef struct packed {
      logic       valid;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rs;
      logic       uses_rt;
      logic [4:0] dst;
      logic       reg_write;
      logic       mem_read;
   } stage_t;

   localparam stage_t STAGE_BUBBLE = '0;

   // Register 0 is hardwired, so a write to it never produces a hazard.
   function automatic logic isLiveWriter(input stage_t s);
      return s.valid & s.reg_write & (s.dst != 5'd0);
   endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline register: captures the incoming stage record when
// i_load is high, otherwise collapses to a bubble.
module hazard_stage_reg
   import hazard_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   i_load,
   input  stage_t i_d,
   output stage_t o_q
);

   stage_t r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_q <= STAGE_BUBBLE;
      else if (i_load)
         r_q <= i_d;
      else
         r_q <= STAGE_BUBBLE;
   end

   assign o_q = r_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Read-after-write hazard resolution for the 5-stage pipeline: shadows the
// in-flight writers, raises the one-cycle load-use stall and picks ALU forwards.
module hazard_forward_unit
   import hazard_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [4:0]       id_dst,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             flush,
   output logic             stall,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   stage_t           w_idRec;
   stage_t           w_ex;
   stage_t           w_mem;
   stage_t           w_wb;
   logic             w_exLoad;
   logic             w_unused;
   logic [CNT_W-1:0] r_stallCount;

   assign w_idRec = '{valid:     id_valid,
                      rs:        id_rs,
                      rt:        id_rt,
                      uses_rs:   id_uses_rs,
                      uses_rt:   id_uses_rt,
                      dst:       id_dst,
                      reg_write: id_reg_write,
                      mem_read:  id_mem_read};

   // A stalled or flushed ID instruction must not enter EX; a bubble goes in instead.
   assign w_exLoad = id_valid & ~stall & ~flush;

   hazard_stage_reg u_exReg (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_exLoad),
      .i_d    (w_idRec),
      .o_q    (w_ex)
   );

   hazard_stage_reg u_memReg (
      .clk    (clk),
      .rst    (rst),
      .i_load (1'b1),
      .i_d    (w_ex),
      .o_q    (w_mem)
   );

   hazard_stage_reg u_wbReg (
      .clk    (clk),
      .rst    (rst),
      .i_load (1'b1),
      .i_d    (w_mem),
      .o_q    (w_wb)
   );

   // Source fields of the two older stages are carried for debug only.
   assign w_unused = ^{w_mem.rs, w_mem.rt, w_mem.uses_rs, w_mem.uses_rt, w_mem.mem_read,
                       w_wb.rs, w_wb.rt, w_wb.uses_rs, w_wb.uses_rt, w_wb.mem_read};

   function automatic logic [1:0] fwdSelect(input logic uses, input logic [4:0] src,
                                            input stage_t mem, input stage_t wb);
      logic [1:0] sel;
      sel = FWD_RF;
      if (uses && isLiveWriter(mem) && (mem.dst == src))
         sel = FWD_MEM;
      else if (uses && isLiveWriter(wb) && (wb.dst == src))
         sel = FWD_WB;
      return sel;
   endfunction

   always_comb begin
      stall = 1'b0;
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (id_valid && !flush && isLiveWriter(w_ex) && w_ex.mem_read &&
          ((id_uses_rs && (id_rs == w_ex.dst)) || (id_uses_rt && (id_rt == w_ex.dst))))
         stall = 1'b1;
      if (w_ex.valid) begin
         fwd_a = fwdSelect(w_ex.uses_rs, w_ex.rs, w_mem, w_wb);
         fwd_b = fwdSelect(w_ex.uses_rt, w_ex.rt, w_mem, w_wb);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_stallCount <= '0;
      else if (stall && (r_stallCount != {CNT_W{1'b1}}))
         r_stallCount <= r_stallCount + CNT_ONE;
   end

   assign stall_count = r_stallCount;

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Tracks in-flight register writes through the EX, MEM and WB stages of the 5-stage MIPS pipeline and resolves read-after-write hazards for the instruction being decoded. It consumes the 5-bit destination index produced by the destination-register mux in ID and shadows it down the pipeline. It issues operand-forwarding selects to the EX-stage ALU input muxes, a one-cycle load-use stall to the PC/IF-ID registers, and a saturating stall count for debug.

## Interface
- `CNT_W`, default 16: width of the stall counter.
- `clk` in 1: pipeline clock; rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: the ID stage holds a real instruction.
- `id_rs` in 5: source A index of the ID instruction.
- `id_rt` in 5: source B index of the ID instruction.
- `id_uses_rs` in 1: the ID instruction reads `rs`.
- `id_uses_rt` in 1: the ID instruction reads `rt`.
- `id_dst` in 5: destination index from the destination mux.
- `id_reg_write` in 1: the ID instruction writes the register file.
- `id_mem_read` in 1: the ID instruction is a load.
- `flush` in 1: kill the ID instruction (branch taken / jump).
- `stall` out 1: hold PC and IF/ID, and inject a bubble into EX.
- `fwd_a` out 2: EX operand A source.
- `fwd_b` out 2: EX operand B source.
- `stall_count` out CNT_W: number of stall cycles since reset; saturating.

## Operation
- **Shadow stages EX, MEM, WB.** Each stage holds `{valid, rs, rt, uses_rs, uses_rt, dst, reg_write, mem_read}`.
- **Advance.** Every cycle MEM→WB and EX→MEM move unconditionally.
- **EX load.** EX loads the ID fields when `id_valid & !stall & !flush`. Otherwise EX loads a bubble with `valid=0`.
- **Live writer.** A stage is a live writer when `valid & reg_write & dst!=0`. Register 0 is never forwarded and never causes a stall.
- **Load-use stall.** `stall = id_valid & !flush & EX live writer & EX.mem_read & ((id_uses_rs & id_rs==EX.dst) | (id_uses_rt & id_rt==EX.dst))`.
  - Combinational, same cycle.
  - Exactly one stall cycle per load-use pair. After the bubble the load is in MEM and forwarding covers the use.
- **Forwarding selects.** `fwd_a` is computed for EX.rs:
  - `2'b01` (FWD_MEM) if EX.uses_rs and MEM is a live writer with a matching dst.
  - Else `2'b10` (FWD_WB) if the same condition holds for WB.
  - Else `2'b00` (FWD_RF).
  - MEM has priority over WB (most recent value).
  - `fwd_b` is computed the same way for EX.rt.
  - When EX.valid=0 both selects are `00`.
- **Writer three ahead.** The register file is write-before-read, so a writer three instructions ahead needs no handling here.
- **Priority.** `flush` has priority over `stall`. With `flush=1`, `stall=0`, and EX receives a bubble.
- **Stall counter.** `stall_count` increments on every cycle with `stall=1` and saturates at all-ones.

## Timing
- **Reset.** All stage valid bits are 0. `stall=0`, `fwd_a=fwd_b=00`, `stall_count=0`.
- **Reset mid-operation.** Reset discards all in-flight entries immediately. This is asynchronous: outputs go to reset values without waiting for a clock edge.
- **Latency.**
  - `stall` is 0-cycle combinational from the ID inputs and EX state.
  - `fwd_*` are combinational from the registered stage state. They are valid for the whole cycle after the clock edge that loaded EX.
- **Load-use sequence.**
  - Cycle n: ID holds the dependent instruction and EX holds the load, so `stall=1`.
  - Cycle n+1: the same ID inputs are presented, EX holds a bubble, MEM holds the load, so `stall=0`.
  - Cycle n+2: the dependent instruction is in EX, the load is in WB, so the matching select is `10`.
- **Double hit.** When both MEM and WB match, MEM wins.
- **Both operands.** When rs==rt, both selects show the same code.

## Structure
- **Package `hazard_pkg`:**
  - `FWD_RF=2'b00`, `FWD_MEM=2'b01`, `FWD_WB=2'b10`.
  - A stage-record typedef (packed struct of the fields listed under Operation) and a bubble constant.
- **Sub-module `hazard_stage_reg`:** one shadow pipeline register with async reset and a load/bubble select. It is instantiated three times.
- **Top level:** comparators, stall logic and the counter stay in the top module.

## Test plan
- **Reset.** Assert `rst` mid-stream with a live load in EX → `stall=0`, fwd `00`, `stall_count=0`, with no clock needed.
- **Load-use.**
  - Stimulus: `lw $8` (dst=8, mem_read) followed by `add` with rs=8.
  - Required: `stall=1` for exactly one cycle, then `fwd_a=10` when the add reaches EX, and `stall_count=1`.
- **ALU back-to-back.**
  - Stimulus: `add $9` (dst=9), then `sub` with rs=9 and rt=9.
  - Required: no stall; `fwd_a=fwd_b=01`.
- **MEM-over-WB priority.**
  - Stimulus: two consecutive writers to $10, then a reader with rt=10.
  - Required: `fwd_b=01`, not `10`.
- **Register zero.**
  - Stimulus: a load with dst=0 followed by a use of rs=0.
  - Required: `stall=0`, `fwd_a=00`.
- **Flush with saturation.**
  - Stimulus: `flush=1` in the same cycle as a load-use match.
  - Required: `stall=0` and EX receives a bubble.
  - With `CNT_W=2`, 5 stall cycles → `stall_count=3`.
